// File: rtl/datagram_transmitter.sv
// Snapshots datagram on accept, sends SYNC/payload(LSB byte first)/CHK as UART 8N1; TxD falls 1 cycle after accept.
// One-deep pending request while busy, extras dropped; TX_CRC8_EN selects CRC-8 (poly 0x07) instead of the byte sum for CHK.
module datagram_transmitter #(
  parameter int          MSG_BYTES    = 64,
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          GAP_BITS     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [MSG_BYTES*8-1:0] datagram,
  input  logic                   send,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   TxD,
  output logic [15:0]            frame_count
);

  localparam int GAP_CLKS = GAP_BITS * CLKS_PER_BIT;
  localparam int CNT_MAX  = (GAP_CLKS > CLKS_PER_BIT) ? GAP_CLKS : CLKS_PER_BIT;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int IDX_W    = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CLKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_BYTES - 1);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, CHECK, GAP} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [3:0]             bit_q, bit_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [8:0]             shift_q, shift_d;
  logic [7:0]             chk_q, chk_d;
  logic [MSG_BYTES*8-1:0] snap_q, snap_d;
  logic                   pending_q, pending_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   txd_q, txd_d;
  logic [15:0]            fcnt_q, fcnt_d;

  logic                   accept;
  logic                   ld;
  logic [7:0]             ld_byte;

  function automatic logic [7:0] chk_step(input logic [7:0] c, input logic [7:0] b);
`ifdef TX_CRC8_EN
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    end
    return r;
`else
    return c + b;
`endif
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    chk_d     = chk_q;
    snap_d    = snap_q;
    pending_d = pending_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    txd_d     = txd_q;
    fcnt_d    = fcnt_q;
    accept    = 1'b0;
    ld        = 1'b0;
    ld_byte   = 8'h00;

    case (state_q)
      IDLE: begin
        if (send) accept = 1'b1;
      end
      SYNC, DATA, CHECK: begin
        if (cnt_q != BIT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (bit_q != 4'd9) begin
          // shift_q carries the stop bit above the data, so bit 9 drives 1
          cnt_d   = '0;
          bit_d   = bit_q + 4'd1;
          txd_d   = shift_q[0];
          shift_d = {1'b1, shift_q[8:1]};
        end else begin
          case (state_q)
            SYNC: begin
              ld      = 1'b1;
              ld_byte = snap_q[7:0];
              chk_d   = chk_step(chk_q, snap_q[7:0]);
              snap_d  = snap_q >> 8;
              idx_d   = '0;
              state_d = DATA;
            end
            DATA: begin
              ld = 1'b1;
              if (idx_q == IDX_LAST) begin
                ld_byte = chk_q;
                state_d = CHECK;
              end else begin
                ld_byte = snap_q[7:0];
                chk_d   = chk_step(chk_q, snap_q[7:0]);
                snap_d  = snap_q >> 8;
                idx_d   = idx_q + 1'b1;
              end
            end
            default: begin
              cnt_d   = '0;
              txd_d   = 1'b1;
              state_d = GAP;
            end
          endcase
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          if (pending_q || send) begin
            accept = 1'b1;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      snap_d    = datagram;
      chk_d     = 8'h00;
      busy_d    = 1'b1;
      pending_d = 1'b0;
      state_d   = SYNC;
      ld        = 1'b1;
      ld_byte   = SYNC_BYTE;
    end else if (send && state_q != IDLE) begin
      pending_d = 1'b1;
    end

    if (ld) begin
      txd_d   = 1'b0;
      shift_d = {1'b1, ld_byte};
      bit_d   = 4'd0;
      cnt_d   = '0;
    end

    // frame_done and the count land together on the final gap cycle
    if (state_d == GAP && cnt_d == GAP_LAST) begin
      done_d = 1'b1;
      fcnt_d = fcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= 4'd0;
      idx_q     <= '0;
      shift_q   <= '0;
      chk_q     <= 8'h00;
      snap_q    <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      txd_q     <= 1'b1;
      fcnt_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      chk_q     <= chk_d;
      snap_q    <= snap_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      txd_q     <= txd_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign TxD         = txd_q;
  assign frame_count = fcnt_q;

endmodule

// File: tb/tb_datagram_transmitter.sv
// Bench for datagram_transmitter: UART line decoder plus a cycle-count level frame model.
module tb_datagram_transmitter;

  localparam int CPB   = 4;
  localparam int GAPB  = 2;
  localparam int NB    = 2;
  localparam int FRAME = (NB + 2) * 10 * CPB + GAPB * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] datagram = 16'h0000;
  logic        send = 1'b0;
  logic        busy, frame_done, TxD;
  logic [15:0] frame_count;

  int n_chk  = 0;
  int n_fail = 0;

  datagram_transmitter #(
    .MSG_BYTES(NB), .CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5), .GAP_BITS(GAPB)
  ) dut (
    .clk(clk), .rst(rst), .datagram(datagram), .send(send),
    .busy(busy), .frame_done(frame_done), .TxD(TxD), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // CHK from the definitions: byte sum, or CRC as remainder of long division
  function automatic logic [7:0] model_chk(input logic [15:0] dg);
`ifdef TX_CRC8_EN
    logic [23:0] v;
    v = {dg[7:0], dg[15:8], 8'h00};
    for (int i = 23; i >= 8; i--)
      if (v[i]) v = v ^ (24'h107 << (i - 8));
    return v[7:0];
`else
    return 8'((int'(dg[7:0]) + int'(dg[15:8])) % 256);
`endif
  endfunction

  // Frame model: frame occupies FRAME cycles from the accept edge
  logic [7:0] exp_q[$];
  int         m_cyc, m_end;
  logic       m_busy, m_pend, m_fd;
  logic [15:0] m_cnt;

  task automatic m_accept(input int c);
    m_busy = 1'b1;
    m_pend = 1'b0;
    m_end  = c + FRAME;
    exp_q.push_back(8'hA5);
    exp_q.push_back(datagram[7:0]);
    exp_q.push_back(datagram[15:8]);
    exp_q.push_back(model_chk(datagram));
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cyc = 0; m_busy = 0; m_pend = 0; m_fd = 0; m_cnt = 0; m_end = 0;
      exp_q.delete();
    end else begin
      m_cyc++;
      m_fd = 1'b0;
      if (m_busy && m_cyc == m_end - 1) begin
        m_fd = 1'b1;
        m_cnt++;
      end
      if (m_busy && m_cyc == m_end) begin
        if (m_pend || send) m_accept(m_cyc);
        else m_busy = 1'b0;
      end else if (!m_busy && send) begin
        m_accept(m_cyc);
      end else if (m_busy && send) begin
        m_pend = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", busy, m_busy);
    check("frame_done", frame_done, m_fd);
    check("frame_count", frame_count, m_cnt);
    if (!m_busy) check("txd_idle", TxD, 1);
  end

  // UART decoder sampling each bit one cycle into its period
  logic [7:0] rx_log[$];
  logic       rx_on = 0, rx_prev = 1;
  int         rx_n = 0;
  logic [7:0] rx_b;
  int         fd_cnt = 0;

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (!rst) begin
      rx_on = 0;
    end else if (!rx_on) begin
      if (!TxD && rx_prev) begin rx_on = 1; rx_n = 0; end
    end else begin
      rx_n++;
      if (rx_n % CPB == 1 && rx_n / CPB >= 1 && rx_n / CPB <= 8)
        rx_b[rx_n / CPB - 1] = TxD;
      if (rx_n == 9 * CPB + 1) begin
        check("stop_bit", TxD, 1);
        rx_log.push_back(rx_b);
        if (exp_q.size() == 0) check("rx_unexpected", exp_q.size(), 1);
        else check("rx_byte", rx_b, exp_q.pop_front());
        rx_on = 0;
      end
    end
    rx_prev = TxD;
  end

  task automatic wait_idle();
    logic ok;
    ok = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (!busy && !m_busy && !rx_on) begin ok = 1; break; end
    end
    check("idle_timeout", ok, 1);
  endtask

  task automatic pulse_send(input logic [15:0] dg);
    @(negedge clk);
    datagram = dg; send = 1;
    @(negedge clk);
    send = 0;
  endtask

  initial begin
    int nbusy, fc0, fd0;
    logic seen;
    // reset then idle
    repeat (3) @(negedge clk);
    rst = 1;
    repeat (200) @(negedge clk);
    check("idle_txd", TxD, 1);
    check("idle_busy", busy, 0);
    check("idle_count", frame_count, 0);

    // single frame
    rx_log.delete();
    fd0 = fd_cnt;
    @(negedge clk);
    datagram = 16'h1234; send = 1;
    check("pre_txd", TxD, 1);
    @(posedge clk); #1;
    check("latency_txd", TxD, 0);
    @(negedge clk);
    send = 0;
    nbusy = 1; seen = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (busy) nbusy++; else begin seen = 1; break; end
    end
    check("busy_end_seen", seen, 1);
    check("busy_cycles", nbusy, FRAME);
    wait_idle();
    check("single_nbytes", rx_log.size(), 4);
    if (rx_log.size() == 4) begin
      check("single_b0", rx_log[0], 8'hA5);
      check("single_b1", rx_log[1], 8'h34);
      check("single_b2", rx_log[2], 8'h12);
      check("single_b3", rx_log[3], 8'h46);
    end
    check("single_fd", fd_cnt - fd0, 1);
    check("single_count", frame_count, 1);

    // snapshot coherence
    rx_log.delete();
    pulse_send(16'h00FF);
    repeat (4) @(negedge clk);
    datagram = 16'hAAAA;
    wait_idle();
    check("snap_nbytes", rx_log.size(), 4);
    if (rx_log.size() == 4) begin
      check("snap_b1", rx_log[1], 8'hFF);
      check("snap_b2", rx_log[2], 8'h00);
      check("snap_b3", rx_log[3], 8'hFF);
    end

    // checksum vector: CRC-8 of 01,02 is 1B, byte sum is 03
    rx_log.delete();
    pulse_send(16'h0201);
    wait_idle();
    check("chk_nbytes", rx_log.size(), 4);
    if (rx_log.size() == 4) begin
`ifdef TX_CRC8_EN
      check("chk_crc", rx_log[3], 8'h1B);
`else
      check("chk_sum", rx_log[3], 8'h03);
`endif
    end

    // pending request: three pulses give exactly two back-to-back frames
    fc0 = frame_count; fd0 = fd_cnt;
    pulse_send(16'hBEEF);
    repeat (30) @(negedge clk);
    pulse_send(16'h5A5A);
    repeat (50) @(negedge clk);
    pulse_send(16'hC3C3);
    seen = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (frame_done) begin seen = 1; break; end
    end
    check("pend_fd_seen", seen, 1);
    @(negedge clk);
    check("pend_start_txd", TxD, 0);
    check("pend_busy", busy, 1);
    wait_idle();
    check("pend_frames", 32'(frame_count - 16'(fc0)), 2);
    check("pend_fd", fd_cnt - fd0, 2);

    // mid-frame reset during payload byte 1
    fd0 = fd_cnt;
    pulse_send(16'h7E81);
    repeat (2 * 10 * CPB + 10 * CPB / 2) @(posedge clk);
    #2 rst = 0;
    #1;
    check("rst_txd", TxD, 1);
    check("rst_busy", busy, 0);
    check("rst_count", frame_count, 0);
    check("rst_fd", frame_done, 0);
    repeat (3) @(negedge clk);
    rst = 1;
    repeat (200) @(negedge clk);
    check("rst_no_fd", fd_cnt - fd0, 0);

    // randomized traffic
    for (int it = 0; it < 8; it++) begin
      int mode;
      mode = it % 3;
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        datagram = 16'($urandom);
        case (mode)
          0: send = ($urandom_range(0, 59) == 0);
          1: send = (c < 250);
          default: send = ($urandom_range(0, 2) == 0);
        endcase
      end
      @(negedge clk);
      send = 0;
      wait_idle();
    end
    check("final_exp_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
